// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits) with a one-entry valid/ready output register.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   i_rx          asynchronous serial line, idles high
//   o_valid       output register holds an unconsumed frame
//   i_ready       consumer accepts the frame (transfer on o_valid && i_ready)
//   o_data        received payload, LSB first on the line
//   o_parity_err  parity mismatch for the held frame (0 when PARITY=0)
//   o_frame_err   a stop-bit sample was 0 for the held frame
//   o_break       framing error with all data bits and parity sample 0
//   o_overrun     one-cycle pulse when a completed frame is dropped
//   o_busy        receiver is not idle
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 2,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bit;
  logic                   stop_idx;
  logic                   ferr_acc;

  logic                   commit_c;
  logic                   stop_bad_c;
  logic                   par_x_c;
  logic                   perr_c;
  logic                   brk_c;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame status as it stands at the final stop sample.
  always_comb begin
    stop_bad_c = ferr_acc | ~rx_s;
    commit_c   = (state == S_STOP) && (cnt == '0) && (stop_idx == STOP_LAST);
    par_x_c    = (^shift) ^ par_bit;
    perr_c     = 1'b0;
    if (PARITY == 1) begin
      perr_c = par_x_c;
    end else if (PARITY == 2) begin
      perr_c = ~par_x_c;
    end
    brk_c = stop_bad_c && (shift == '0) && !par_bit;
  end

  // Receive FSM; o_busy tracks the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      stop_idx <= 1'b0;
      ferr_acc <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt    <= CNT_HALF;
            state  <= S_START;
            o_busy <= 1'b1;
          end
        end
        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_s) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt      <= CNT_FULL;
            idx      <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift[idx] <= rx_s;
            cnt        <= CNT_FULL;
            if (idx == IDX_LAST) begin
              state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_PAR: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            par_bit <= rx_s;
            cnt     <= CNT_FULL;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (commit_c) begin
            // Leave at the final stop sample; a low line must return high first.
            state  <= stop_bad_c ? S_WAIT_HIGH : S_IDLE;
            o_busy <= stop_bad_c;
          end else begin
            stop_idx <= 1'b1;
            ferr_acc <= stop_bad_c;
            cnt      <= CNT_FULL;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output register with overrun on a blocked commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (commit_c) begin
        if (!o_valid || i_ready) begin
          o_valid      <= 1'b1;
          o_data       <= shift;
          o_parity_err <= perr_c;
          o_frame_err  <= stop_bad_c;
          o_break      <= brk_c;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
